wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 55 +++++
 rtl/wb_regfile_if.sv | 35 +++
 rtl/wb_regfile_regfile.sv | 50 +++++
 rtl/wb_regfile.sv | 69 ++++++
 tb/tb_wb_regfile.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared writeback-stage definitions: select encodings, RV32I opcodes and the
// WB stage register layout used by wb_ctrl and wb_regfile.
package wb_regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC4 = 2'd2,
    WB_SEL_RSV = 2'd3
  } wb_sel_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic                  valid;
    logic                  write_to_reg;
    wb_sel_e               sel;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       load_data;
    logic [XLEN-1:0]       pc_plus4;
  } wb_stage_t;

  // The reserved encoding falls back to the ALU result.
  function automatic logic [XLEN-1:0] wb_select(
    input wb_sel_e         sel,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] mem,
    input logic [XLEN-1:0] pc4
  );
    logic [XLEN-1:0] result;
    case (sel)
      WB_SEL_ALU: result = alu;
      WB_SEL_MEM: result = mem;
      WB_SEL_PC4: result = pc4;
      default:    result = alu;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Bus between the MEM/decode stages and the writeback stage with its register file.
interface wb_regfile_if;

  logic        in_valid;
  logic        stall;
  logic        flush;
  logic        write_to_reg;
  logic [1:0]  data_to_reg_sel;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic [31:0] load_data;
  logic [31:0] pc_plus4;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] retired;

  modport master (
    output in_valid, stall, flush, write_to_reg, data_to_reg_sel, rd,
           alu_result, load_data, pc_plus4, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_valid, wb_we, wb_rd, wb_data, retired
  );

  modport slave (
    input  in_valid, stall, flush, write_to_reg, data_to_reg_sel, rd,
           alu_result, load_data, pc_plus4, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_valid, wb_we, wb_rd, wb_data, retired
  );

endinterface

// File: rtl/wb_regfile_regfile.sv
// 32 x 32 register file: two combinational read ports with write-first bypass,
// one write port, x0 hard-wired to zero.
module regfile
  import wb_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]       rdata1,
  output logic [XLEN-1:0]       rdata2
);

  logic [XLEN-1:0] mem_r [NUM_REGS];

  // Register array; reset wins over any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (we && (waddr != 5'd0)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read ports: x0 reads zero, a same-cycle write is forwarded.
  always_comb begin
    rdata1 = 32'd0;
    rdata2 = 32'd0;
    if (raddr1 == 5'd0) begin
      rdata1 = 32'd0;
    end else if (we && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = mem_r[raddr1];
    end
    if (raddr2 == 5'd0) begin
      rdata2 = 32'd0;
    end else if (we && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = mem_r[raddr2];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: WB pipeline register, writeback mux, register file and
// retired-instruction counter.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  wb_stage_t       stage_r;
  logic [31:0]     retired_r;
  logic [XLEN-1:0] wb_data_s;
  logic            wb_we_s;
  logic            wr_en_s;

  // WB stage register; flush only kills the valid bit and overrides stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r <= '0;
    end else if (bus.flush) begin
      stage_r.valid <= 1'b0;
    end else if (!bus.stall) begin
      stage_r.valid        <= bus.in_valid;
      stage_r.write_to_reg <= bus.write_to_reg;
      stage_r.sel          <= wb_sel_e'(bus.data_to_reg_sel);
      stage_r.rd           <= bus.rd;
      stage_r.alu_result   <= bus.alu_result;
      stage_r.load_data    <= bus.load_data;
      stage_r.pc_plus4     <= bus.pc_plus4;
    end
  end

  // Retired counter; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_r <= 32'd0;
    end else if (stage_r.valid && !bus.stall) begin
      retired_r <= retired_r + 32'd1;
    end
  end

  // Writeback value and write enable; a stalled instruction writes only on release.
  always_comb begin
    wb_data_s = wb_select(stage_r.sel, stage_r.alu_result,
                          stage_r.load_data, stage_r.pc_plus4);
    wb_we_s   = stage_r.valid && stage_r.write_to_reg && (stage_r.rd != 5'd0);
    wr_en_s   = wb_we_s && !bus.stall;
  end

  regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wr_en_s),
    .waddr  (stage_r.rd),
    .wdata  (wb_data_s),
    .raddr1 (bus.rs1_addr),
    .raddr2 (bus.rs2_addr),
    .rdata1 (bus.rs1_data),
    .rdata2 (bus.rs2_data)
  );

  assign bus.wb_valid = stage_r.valid;
  assign bus.wb_we    = wb_we_s;
  assign bus.wb_rd    = stage_r.rd;
  assign bus.wb_data  = wb_data_s;
  assign bus.retired  = retired_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed scenarios plus randomized traffic for wb_regfile, checked against a
// behavioural model of the WB stage, register array and retire count.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_rf [32];
  logic        m_valid;
  logic        m_wtr;
  logic [1:0]  m_sel;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_load, m_pc4;
  logic [31:0] m_ret;
  logic [31:0] r0;

  function automatic logic [31:0] m_data();
    if (m_sel == 2'd1) return m_load;
    if (m_sel == 2'd2) return m_pc4;
    return m_alu;
  endfunction

  function automatic logic m_we();
    return m_valid && m_wtr && (m_rd != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_we() && !bus.stall && (a == m_rd)) return m_data();
    return m_rf[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic wtr, input logic [1:0] sel,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [31:0] pc4);
    bus.in_valid        = v;
    bus.write_to_reg    = wtr;
    bus.data_to_reg_sel = sel;
    bus.rd              = rd;
    bus.alu_result      = alu;
    bus.load_data       = ld;
    bus.pc_plus4        = pc4;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Compare every output with the model, just before the next rising edge
  task automatic settle_check();
    #1;
    check("wb_valid", {31'd0, bus.wb_valid}, {31'd0, m_valid});
    check("wb_we",    {31'd0, bus.wb_we},    {31'd0, m_we()});
    check("wb_rd",    {27'd0, bus.wb_rd},    {27'd0, m_rd});
    check("wb_data",  bus.wb_data,           m_data());
    check("rs1_data", bus.rs1_data,          m_read(bus.rs1_addr));
    check("rs2_data", bus.rs2_data,          m_read(bus.rs2_addr));
    check("retired",  bus.retired,           m_ret);
  endtask

  // Advance one edge and apply the architectural rules to the model
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_valid = 1'b0; m_wtr = 1'b0; m_sel = 2'd0; m_rd = 5'd0;
      m_alu = 32'd0; m_load = 32'd0; m_pc4 = 32'd0; m_ret = 32'd0;
    end else begin
      if (!bus.stall) begin
        if (m_we()) m_rf[m_rd] = m_data();
        if (m_valid) m_ret = m_ret + 32'd1;
      end
      if (bus.flush) begin
        m_valid = 1'b0;
      end else if (!bus.stall) begin
        m_valid = bus.in_valid;  m_wtr  = bus.write_to_reg;
        m_sel   = bus.data_to_reg_sel; m_rd = bus.rd;
        m_alu   = bus.alu_result; m_load = bus.load_data; m_pc4 = bus.pc_plus4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
    bubble();
    @(posedge clk);
    @(negedge clk);
    tick();
    settle_check();                // reset state (rst still high)
    rst = 1'b0;
    tick();

    // Load to x5
    drive(1'b1, 1'b1, 2'd1, 5'd5, 32'h1111_0000, 32'hDEAD_BEEF, 32'h0000_0040);
    settle_check(); tick();
    bubble(); bus.rs1_addr = 5'd5;
    settle_check();
    check("load_we",     {31'd0, bus.wb_we}, 32'd1);
    check("load_data",   bus.wb_data,  32'hDEAD_BEEF);
    check("load_bypass", bus.rs1_data, 32'hDEAD_BEEF);
    tick();
    settle_check();
    check("load_read",    bus.rs1_data, 32'hDEAD_BEEF);
    check("load_retired", bus.retired,  32'd1);
    tick();

    // JAL with rd=0
    drive(1'b1, 1'b1, 2'd2, 5'd0, 32'h0000_0999, 32'd0, 32'h0000_0104);
    bus.rs1_addr = 5'd0;
    settle_check(); tick();
    bubble();
    settle_check();
    check("jal_we",   {31'd0, bus.wb_we}, 32'd0);
    check("jal_data", bus.wb_data,  32'h0000_0104);
    check("jal_x0",   bus.rs1_data, 32'd0);
    tick();
    settle_check();
    check("jal_retired", bus.retired, 32'd2);

    // Same-cycle bypass on rs2
    drive(1'b1, 1'b1, 2'd0, 5'd7, 32'h1234_5678, 32'd0, 32'd0);
    settle_check(); tick();
    bubble(); bus.rs2_addr = 5'd7;
    settle_check();
    check("bypass_rs2", bus.rs2_data, 32'h1234_5678);
    tick();

    // Stall an ADD to x3 for three cycles, then release
    drive(1'b1, 1'b1, 2'd0, 5'd3, 32'h0000_0033, 32'd0, 32'd0);
    bus.rs1_addr = 5'd3;
    settle_check(); tick();
    r0 = m_ret;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'd0, 5'd3, $urandom, $urandom, $urandom);
      settle_check();
      check("stall_x3",      bus.rs1_data, 32'd0);
      check("stall_retired", bus.retired,  r0);
      tick();
    end
    bus.stall = 1'b0; bubble();
    settle_check(); tick();
    settle_check();
    check("release_x3",      bus.rs1_data, 32'h0000_0033);
    check("release_retired", bus.retired,  r0 + 32'd1);
    tick();

    // Flush while stalled: instruction to x4 vanishes
    drive(1'b1, 1'b1, 2'd0, 5'd4, 32'h0000_0044, 32'd0, 32'd0);
    bus.rs1_addr = 5'd4;
    settle_check(); tick();
    bus.stall = 1'b1; bus.flush = 1'b1; bubble();
    settle_check(); tick();
    bus.stall = 1'b0; bus.flush = 1'b0;
    settle_check();
    check("flush_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("flush_x4",    bus.rs1_data, 32'd0);
    tick();

    // Reset mid-operation with a pending write to x9
    drive(1'b1, 1'b1, 2'd0, 5'd9, 32'h0000_00A5, 32'd0, 32'd0);
    bus.rs1_addr = 5'd9;
    settle_check(); tick();
    drive(1'b1, 1'b1, 2'd0, 5'd9, 32'h0000_005A, 32'd0, 32'd0);
    settle_check(); tick();
    check("pre_rst_x9", m_rf[9], 32'h0000_00A5);
    rst = 1'b1; bus.stall = 1'b1; bus.flush = 1'b1; bubble();
    settle_check(); tick();
    rst = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    settle_check();
    check("rst_x9",      bus.rs1_data, 32'd0);
    check("rst_retired", bus.retired,  32'd0);
    check("rst_valid",   {31'd0, bus.wb_valid}, 32'd0);
    tick();

    // Counter wrap: hold a valid instruction, preload the counter, release
    drive(1'b1, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    settle_check(); tick();
    bus.stall = 1'b1; bubble();
    force dut.retired_r = 32'hFFFF_FFFF;
    #1;
    release dut.retired_r;
    m_ret = 32'hFFFF_FFFF;
    settle_check(); tick();
    bus.stall = 1'b0;
    settle_check(); tick();
    settle_check();
    check("wrap_retired", bus.retired, 32'd0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom);
      bus.rs1_addr = 5'($urandom_range(0, 7));
      bus.rs2_addr = 5'($urandom_range(0, 31));
      settle_check();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
